// File: rtl/scc_pkg.sv
// Shared definitions for the SCC memory responder.
//   WORD_W     : data word width
//   state_t    : responder FSM states
//   word_legal : true when a byte address is word-aligned and inside the array
package scc_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    // The limit is computed two bits wider than the address so that
    // depth*4 cannot wrap for large arrays.
    function automatic logic word_legal(input logic [WORD_W-1:0] addr,
                                        input int unsigned       depth);
        logic [WORD_W+1:0] limit;
        limit = (WORD_W+2)'(depth) << 2;
        return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
    endfunction

endpackage

// File: rtl/scc_ram.sv
// DEPTH x WORD_W word array with one write port and two synchronous read
// ports (fetch, data). Each read port updates only when enabled; a clear
// request loads zero instead of array data. A same-cycle write to the word
// being read is forwarded to that read port (write-first).
// Ports:
//   clk, reset            : clock, async active-high reset (read registers only)
//   we, waddr, wdata      : write port
//   f_en, f_clr, f_addr   : fetch read request, f_data registered result
//   d_en, d_clr, d_addr   : data read request, d_data registered result
module scc_ram
    import scc_pkg::*;
#(
    parameter  int unsigned DEPTH = 1024,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              f_en,
    input  logic              f_clr,
    input  logic [IDX_W-1:0]  f_addr,
    output logic [WORD_W-1:0] f_data,
    input  logic              d_en,
    input  logic              d_clr,
    input  logic [IDX_W-1:0]  d_addr,
    output logic [WORD_W-1:0] d_data
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] f_data_q, d_data_q;
    logic [WORD_W-1:0] f_data_d, d_data_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        f_data_d = f_data_q;
        if (f_en) begin
            if (f_clr) begin
                f_data_d = '0;
            end else if (we && (waddr == f_addr)) begin
                f_data_d = wdata;
            end else begin
                f_data_d = mem[f_addr];
            end
        end
    end

    always_comb begin
        d_data_d = d_data_q;
        if (d_en) begin
            if (d_clr) begin
                d_data_d = '0;
            end else if (we && (waddr == d_addr)) begin
                d_data_d = wdata;
            end else begin
                d_data_d = mem[d_addr];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_data_q <= '0;
            d_data_q <= '0;
        end else begin
            f_data_q <= f_data_d;
            d_data_q <= d_data_d;
        end
    end

    assign f_data = f_data_q;
    assign d_data = d_data_q;

endmodule

// File: rtl/scc_mem_responder.sv
// Memory-side responder for the SCC core's fetch and load/store channels.
// After reset the array is zeroed one word per cycle (INIT) unless
// INIT_CLEAR is 0; afterwards (RUN) fetches and loads return data one cycle
// after the request and stores write the array. The first illegal access
// (misaligned or out of range) is latched in fault/fault_addr until reset.
// Ports:
//   clk, reset                       : clock, async active-high reset
//   in_mem_addr, in_mem_en, in_mem   : instruction fetch channel
//   data_addr, data_out, data_read,
//   data_write, data_in              : data load/store channel
//   mem_ready                        : high in RUN; requests ignored while low
//   fault, fault_addr                : sticky first-illegal-access capture
module scc_mem_responder
    import scc_pkg::*;
#(
    parameter  int unsigned DEPTH      = 1024,
    parameter  bit          INIT_CLEAR = 1'b1,
    localparam int unsigned IDX_W      = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_mem_addr,
    input  logic        in_mem_en,
    output logic [31:0] in_mem,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    input  logic        data_read,
    input  logic        data_write,
    output logic [31:0] data_in,
    output logic        mem_ready,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam state_t           RESET_STATE = INIT_CLEAR ? ST_INIT : ST_RUN;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              fault_q, fault_d;
    logic [31:0]       fault_addr_q, fault_addr_d;

    logic              f_legal, d_legal;
    logic              f_fault, d_fault;
    logic [IDX_W-1:0]  f_idx, d_idx;

    logic              ram_we;
    logic [IDX_W-1:0]  ram_waddr;
    logic [WORD_W-1:0] ram_wdata;
    logic              ram_f_en, ram_d_en;

    assign f_legal = word_legal(in_mem_addr, DEPTH);
    assign d_legal = word_legal(data_addr, DEPTH);
    assign f_idx   = in_mem_addr[IDX_W+1:2];
    assign d_idx   = data_addr[IDX_W+1:2];
    assign f_fault = in_mem_en && !f_legal;
    assign d_fault = (data_read || data_write) && !d_legal;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT: if (cnt_q == LAST_IDX) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
        endcase
    end

    // Output / datapath control. Requests are gated by the registered ready
    // flag, so with INIT_CLEAR=0 the first cycle after reset still ignores
    // requests while mem_ready is low.
    always_comb begin
        ready_d      = (state_d == ST_RUN);
        cnt_d        = cnt_q;
        ram_we       = 1'b0;
        ram_waddr    = d_idx;
        ram_wdata    = data_out;
        ram_f_en     = 1'b0;
        ram_d_en     = 1'b0;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;

        if (state_q == ST_INIT) begin
            ram_we    = 1'b1;
            ram_waddr = cnt_q;
            ram_wdata = '0;
            cnt_d     = cnt_q + 1'b1;
        end else if (ready_q) begin
            ram_we   = data_write && d_legal;
            ram_f_en = in_mem_en;
            ram_d_en = data_read;
            // Data channel wins when both channels fault in the same cycle.
            if (!fault_q) begin
                if (d_fault) begin
                    fault_d      = 1'b1;
                    fault_addr_d = data_addr;
                end else if (f_fault) begin
                    fault_d      = 1'b1;
                    fault_addr_d = in_mem_addr;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            ready_q      <= ready_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    scc_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (ram_wdata),
        .f_en   (ram_f_en),
        .f_clr  (!f_legal),
        .f_addr (f_idx),
        .f_data (in_mem),
        .d_en   (ram_d_en),
        .d_clr  (!d_legal),
        .d_addr (d_idx),
        .d_data (data_in)
    );

    assign mem_ready  = ready_q;
    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;

endmodule

// File: doc/scc_mem_responder.md
Name: scc_mem_responder

Overview:
- Memory-side responder for the SCC core's two memory channels: the instruction fetch channel and the data load/store channel.
- Holds one shared word array. Serves instruction fetches and data reads with 1-cycle latency, and performs data writes.
- After reset, clears the array (INIT) before reporting ready. Latches the first illegal access for debug.
- Sits between the SCC core and the testbench/top level, in place of a behavioural memory model.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two, ≥ 4)
- INIT_CLEAR, 1, 1 = zero the array after reset; 0 = skip INIT and go directly to RUN
- IDX_W, $clog2(DEPTH), derived localparam, word index width

Ports:
- clk  input  1  main clock, all state on rising edge
- reset  input  1  asynchronous, active-high; forces INIT state and clears all outputs
- in_mem_addr  input  32  byte address of the instruction fetch
- in_mem_en  input  1  fetch request this cycle
- in_mem  output  32  fetched instruction, valid the cycle after the request
- data_addr  input  32  byte address of the data access
- data_out  input  32  store data from the core
- data_read  input  1  load request this cycle
- data_write  input  1  store request this cycle
- data_in  output  32  load data to the core, valid the cycle after the request
- mem_ready  output  1  high in RUN; accesses are ignored while low
- fault  output  1  sticky illegal-access flag
- fault_addr  output  32  byte address of the first illegal access

Behaviour:
- Reset values: in_mem=0, data_in=0, mem_ready=0, fault=0, fault_addr=0, init counter=0, state=INIT (RUN if INIT_CLEAR=0).
- Reset is asynchronous. Asserting it mid-operation aborts any access and restarts INIT; array contents are then undefined until INIT rewrites them.
- Addressing: word index = addr[IDX_W+1:2]. An access is legal only if addr[1:0]==0 and addr < DEPTH*4.
- FSM states: INIT, RUN.
  - INIT: each cycle writes 0 to array[cnt] and increments cnt. When cnt==DEPTH-1, it goes to RUN on the next edge.
  - INIT lasts exactly DEPTH cycles after reset deasserts. During INIT, mem_ready=0, all requests are ignored (no write, no fault), and in_mem/data_in hold 0.
  - RUN: mem_ready=1 and stays there until reset.
- Fetch (RUN, in_mem_en=1):
  - Legal: in_mem <= array[idx] at the edge.
  - Illegal: in_mem <= 0.
  - in_mem_en=0: in_mem holds its previous value.
- Load (RUN, data_read=1): same rules as fetch, applied to data_in. With no request, data_in holds.
- Store (RUN, data_write=1, legal): array[idx] <= data_out at the edge. An illegal store is suppressed and the array is unchanged.
- Store and load in the same cycle: the store is performed and data_in <= data_out (write-first).
- Store and fetch to the same legal word in the same cycle: in_mem <= data_out (write-first forwarding).
- Fault capture:
  - On the first illegal request in RUN, fault <= 1 and fault_addr captures that address. Priority when both channels fault in one cycle: data channel first.
  - Later faults do not update fault_addr. Both are cleared only by reset.
- Latency: exactly 1 cycle from request edge to output. Back-to-back requests every cycle are supported with no stalls.

Decomposition:
- Package scc_pkg holds:
  - WORD_W=32
  - state enum {ST_INIT, ST_RUN}
  - function word_legal(addr, depth)
- One sub-module, scc_ram: DEPTH×32 array with one write port and two synchronous read ports, with write-first bypass on both read ports.
- The top level contains the FSM, the init counter, the request gating and the fault logic.

Test Plan:
- Reset with DEPTH=16, INIT_CLEAR=1 → mem_ready stays 0 for exactly 16 cycles, then 1. A fetch of 0x0000_0020 then returns 0x0000_0000.
- RUN: store 0xDEAD_BEEF to 0x0000_0008, then load 0x0000_0008 next cycle → data_in=0xDEAD_BEEF one cycle after the load. A fetch of 0x0000_0008 gives the same in_mem.
- Same cycle: store 0x1234_5678 plus load to 0x0000_000C → data_in=0x1234_5678 next cycle. Store plus fetch to the same word → in_mem=0x1234_5678.
- Illegal accesses in order: load 0x0000_0006 (misaligned), then store to 0x0000_0040 (out of range, DEPTH=16) → fault=1, fault_addr=0x0000_0006, data_in=0. The second fault leaves fault_addr unchanged and the array is unmodified.
- Assert reset for 1 cycle mid-stream after storing 0xAAAA_AAAA to 0x4 → outputs clear immediately, INIT reruns, and a load of 0x4 after ready returns 0.
- INIT_CLEAR=0 → mem_ready=1 on the first edge after reset. Requests issued during INIT (INIT_CLEAR=1) → no fault and no array write.
